// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with stall, flush-to-bubble and branch resolve.
// Define ID_EX_PERF_CNT_EN to add saturating bubble/stall/taken counters.
module id_ex_pipe_reg #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int ALUCTL_W = 5,
  parameter int RES_W    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_e,
  input  logic                flush_e,
  input  logic                valid_d,
  input  logic [XLEN-1:0]     RD1,
  input  logic [XLEN-1:0]     RD2,
  input  logic [XLEN-1:0]     PCD,
  input  logic [XLEN-1:0]     PCPlus4D,
  input  logic [XLEN-1:0]     ImmExtD,
  input  logic [REG_AW-1:0]   RdD,
  input  logic [REG_AW-1:0]   Rs1D,
  input  logic [REG_AW-1:0]   Rs2D,
  input  logic                RegWriteD,
  input  logic                MemWriteD,
  input  logic                ALUSrcD,
  input  logic                BranchD,
  input  logic                JumpD,
  input  logic [RES_W-1:0]    ResultSrcD,
  input  logic [ALUCTL_W-1:0] ALUControlD,
  input  logic [2:0]          funct3D,
  input  logic                ZeroE,
  input  logic                NegE,
  input  logic                CarryE,
  input  logic                OvfE,
  output logic [XLEN-1:0]     RD1E,
  output logic [XLEN-1:0]     RD2E,
  output logic [XLEN-1:0]     PCE,
  output logic [XLEN-1:0]     PCPlus4E,
  output logic [XLEN-1:0]     ImmExtE,
  output logic [REG_AW-1:0]   RdE,
  output logic [REG_AW-1:0]   Rs1E,
  output logic [REG_AW-1:0]   Rs2E,
  output logic                RegWriteE,
  output logic                MemWriteE,
  output logic                ALUSrcE,
  output logic                BranchE,
  output logic                JumpE,
  output logic [RES_W-1:0]    ResultSrcE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic [2:0]          funct3E,
  output logic                validE,
  output logic                BranchTakenE,
  output logic                PCSrcE
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    bubble_cnt,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    taken_cnt
`endif
);

  logic cond;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validE    <= 1'b0;
      RegWriteE <= 1'b0;
      MemWriteE <= 1'b0;
      BranchE   <= 1'b0;
      JumpE     <= 1'b0;
      RdE       <= '0;
      Rs1E      <= '0;
      Rs2E      <= '0;
    end else if (flush_e) begin
      validE    <= 1'b0;
      RegWriteE <= 1'b0;
      MemWriteE <= 1'b0;
      BranchE   <= 1'b0;
      JumpE     <= 1'b0;
      RdE       <= '0;
      Rs1E      <= '0;
      Rs2E      <= '0;
    end else if (!stall_e) begin
      validE    <= valid_d;
      RegWriteE <= RegWriteD & valid_d;
      MemWriteE <= MemWriteD & valid_d;
      BranchE   <= BranchD & valid_d;
      JumpE     <= JumpD & valid_d;
      RdE       <= RdD;
      Rs1E      <= Rs1D;
      Rs2E      <= Rs2D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RD1E        <= '0;
      RD2E        <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      ImmExtE     <= '0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      funct3E     <= '0;
    end else if (!flush_e && !stall_e) begin
      RD1E        <= RD1;
      RD2E        <= RD2;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      ImmExtE     <= ImmExtD;
      ALUSrcE     <= ALUSrcD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
      funct3E     <= funct3D;
    end
  end

  always_comb begin
    cond = 1'b0;
    case (funct3E)
      3'b000:  cond = ZeroE;
      3'b001:  cond = !ZeroE;
      3'b100:  cond = NegE ^ OvfE;
      3'b101:  cond = !(NegE ^ OvfE);
      3'b110:  cond = !CarryE;
      3'b111:  cond = CarryE;
      default: cond = 1'b0;
    endcase
  end

  assign BranchTakenE = validE & BranchE & cond;
  assign PCSrcE       = BranchTakenE | (validE & JumpE);

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
      taken_cnt  <= '0;
    end else begin
      if (flush_e && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 1'b1;
      if (stall_e && !flush_e && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (PCSrcE && !stall_e && taken_cnt != '1)
        taken_cnt <= taken_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg.
// Counter checks run when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_e = 1'b0;
  logic        flush_e = 1'b0;
  logic        valid_d = 1'b0;
  logic [31:0] RD1 = '0, RD2 = '0, PCD = '0;
  logic [31:0] PCPlus4D = '0, ImmExtD = '0;
  logic [4:0]  RdD = '0, Rs1D = '0, Rs2D = '0;
  logic        RegWriteD = 0, MemWriteD = 0;
  logic        ALUSrcD = 0, BranchD = 0, JumpD = 0;
  logic [1:0]  ResultSrcD = '0;
  logic [4:0]  ALUControlD = '0;
  logic [2:0]  funct3D = '0;
  logic        ZeroE = 0, NegE = 0, CarryE = 0, OvfE = 0;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  RdE, Rs1E, Rs2E;
  logic        RegWriteE, MemWriteE, ALUSrcE;
  logic        BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [4:0]  ALUControlE;
  logic [2:0]  funct3E;
  logic        validE, BranchTakenE, PCSrcE;
`ifdef ID_EX_PERF_CNT_EN
  logic [3:0]  bubble_cnt, stall_cnt, taken_cnt;
  int          bub_m = 0, stl_m = 0, tkn_m = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        pc_ok;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        rw, mw, br, jp, vld;
    logic [2:0]  f3;
  } exp_t;

  exp_t        m;
  exp_t        q[$];
  logic [31:0] op_a = '0, op_b = '0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d),
    .RD1(RD1), .RD2(RD2), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .BranchD(BranchD),
    .JumpD(JumpD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .funct3D(funct3D),
    .ZeroE(ZeroE), .NegE(NegE),
    .CarryE(CarryE), .OvfE(OvfE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE),
    .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .funct3E(funct3E),
    .validE(validE), .BranchTakenE(BranchTakenE),
    .PCSrcE(PCSrcE)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .bubble_cnt(bubble_cnt),
    .stall_cnt(stall_cnt),
    .taken_cnt(taken_cnt)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_cond(input logic [2:0] f,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic exp_taken();
    return m.vld & m.br & exp_cond(m.f3, op_a, op_b);
  endfunction

  function automatic logic exp_src();
    return exp_taken() | (m.vld & m.jp);
  endfunction

  task automatic set_ops(input logic [31:0] a,
                         input logic [31:0] b);
    logic [31:0] d;
    op_a = a;
    op_b = b;
    d = a - b;
    ZeroE  = (d == 32'd0);
    NegE   = d[31];
    CarryE = (a >= b);
    OvfE   = (a[31] != b[31]) && (d[31] != a[31]);
  endtask

  task automatic rand_d();
    valid_d = 1'($urandom);
    RD1 = $urandom; RD2 = $urandom;
    PCD = $urandom; PCPlus4D = $urandom;
    ImmExtD = $urandom;
    RdD = 5'($urandom); Rs1D = 5'($urandom);
    Rs2D = 5'($urandom);
    RegWriteD = 1'($urandom); MemWriteD = 1'($urandom);
    ALUSrcD = 1'($urandom); BranchD = 1'($urandom);
    JumpD = 1'($urandom);
    ResultSrcD = 2'($urandom);
    ALUControlD = 5'($urandom);
    funct3D = 3'($urandom);
  endtask

  task automatic load_d(input logic v, input logic [31:0] pc,
                        input logic [4:0] rd, input logic rw,
                        input logic mw, input logic br,
                        input logic jp, input logic [2:0] f3);
    valid_d = v; PCD = pc; RdD = rd;
    RegWriteD = rw; MemWriteD = mw;
    BranchD = br; JumpD = jp; funct3D = f3;
  endtask

  task automatic step();
    exp_t e;
`ifdef ID_EX_PERF_CNT_EN
    if (flush_e && bub_m != 15) bub_m++;
    if (stall_e && !flush_e && stl_m != 15) stl_m++;
    if (exp_src() && !stall_e && tkn_m != 15) tkn_m++;
`endif
    if (flush_e) begin
      m.vld = 0; m.rw = 0; m.mw = 0;
      m.br = 0; m.jp = 0;
      m.rd = 0; m.rs1 = 0; m.pc_ok = 0;
    end else if (!stall_e) begin
      m.vld = valid_d;
      m.rw = RegWriteD & valid_d;
      m.mw = MemWriteD & valid_d;
      m.br = BranchD & valid_d;
      m.jp = JumpD & valid_d;
      m.rd = RdD; m.rs1 = Rs1D;
      m.pc = PCD; m.pc_ok = 1;
      m.f3 = funct3D;
    end
    q.push_back(m);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check("validE", 32'(validE), 32'(e.vld));
      check("RegWriteE", 32'(RegWriteE), 32'(e.rw));
      check("MemWriteE", 32'(MemWriteE), 32'(e.mw));
      check("BranchE", 32'(BranchE), 32'(e.br));
      check("JumpE", 32'(JumpE), 32'(e.jp));
      check("RdE", 32'(RdE), 32'(e.rd));
      check("Rs1E", 32'(Rs1E), 32'(e.rs1));
      if (e.pc_ok) check("PCE", PCE, e.pc);
      check("PCSrcE", 32'(PCSrcE), 32'(exp_src()));
`ifdef ID_EX_PERF_CNT_EN
      check("bubble_cnt", 32'(bubble_cnt), 32'(bub_m));
      check("stall_cnt", 32'(stall_cnt), 32'(stl_m));
      check("taken_cnt", 32'(taken_cnt), 32'(tkn_m));
`endif
    end
  endtask

  task automatic br_check(input string tag,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic exp);
    set_ops(a, b);
    #1;
    check(tag, 32'(PCSrcE), 32'(exp));
    check({tag, "_bt"}, 32'(BranchTakenE), 32'(exp));
  endtask

  initial begin
    m = '{default: '0};
    m.pc_ok = 1;
    set_ops(32'd3, 32'd9);

    for (int i = 0; i < 4; i++) begin
      rand_d();
      @(negedge clk);
      check("rst_validE", 32'(validE), 32'd0);
      check("rst_PCSrcE", 32'(PCSrcE), 32'd0);
      check("rst_PCE", PCE, 32'd0);
      check("rst_RD1E", RD1E, 32'd0);
      check("rst_ctl", {RegWriteE, MemWriteE, ALUSrcE,
            BranchE, JumpE, ResultSrcE, ALUControlE,
            funct3E, RdE, Rs1E, Rs2E}, 32'd0);
    end
    rst = 1'b1;

    load_d(1, 32'h100, 5'd5, 1, 0, 0, 0, 3'd0);
    Rs1D = 5'd3;
    step();

    load_d(1, 32'h200, 5'd9, 1, 0, 0, 0, 3'd0);
    step();
    stall_e = 1;
    PCD = 32'h204; step();
    PCD = 32'h208; step();
    PCD = 32'h20C; step();
    stall_e = 0;
    step();

    load_d(1, 32'h300, 5'd7, 1, 1, 0, 1, 3'd0);
    stall_e = 1; flush_e = 1;
    step();
    check("flush_RdE", 32'(RdE), 32'd0);
    stall_e = 0; flush_e = 0;

    load_d(1, 32'h400, 5'd0, 0, 0, 1, 0, 3'b100);
    step();
    br_check("blt_n1v0", 32'd1, 32'd2, 1);
    br_check("blt_n1v1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
    load_d(1, 32'h404, 5'd0, 0, 0, 1, 0, 3'b110);
    step();
    br_check("bltu_c0", 32'd1, 32'd2, 1);
    br_check("bltu_c1", 32'd2, 32'd1, 0);
    load_d(1, 32'h408, 5'd0, 0, 0, 1, 0, 3'b001);
    step();
    br_check("bne_z1", 32'd5, 32'd5, 0);

    for (int f = 0; f < 8; f++) begin
      load_d(1, 32'h500, 5'd0, 0, 0, 1, 0, 3'(f));
      step();
      for (int k = 0; k < 5; k++) begin
        logic [31:0] a, b;
        a = $urandom;
        b = (k == 0) ? a : $urandom;
        if (k == 1) begin a = 32'h8000_0000; b = 32'd1; end
        if (k == 2) b = a ^ 32'h8000_0000;
        br_check($sformatf("f3_%0d_%0d", f, k), a, b,
                 exp_cond(3'(f), a, b));
      end
    end

    load_d(0, 32'h600, 5'd0, 0, 0, 1, 0, 3'b000);
    step();
    br_check("inv_beq", 32'd4, 32'd4, 0);

    load_d(0, 32'h604, 5'd11, 1, 1, 0, 1, 3'd0);
    step();

    load_d(1, 32'h700, 5'd1, 1, 0, 0, 1, 3'd0);
    step();
    stall_e = 1;
    load_d(1, 32'h704, 5'd2, 0, 0, 0, 0, 3'd0);
    step();
    step();
    stall_e = 0;
    step();

    for (int i = 0; i < 40; i++) begin
      rand_d();
      stall_e = ($urandom_range(0, 3) == 0);
      flush_e = ($urandom_range(0, 4) == 0);
      set_ops($urandom, $urandom);
      step();
    end
    stall_e = 0; flush_e = 0;

`ifdef ID_EX_PERF_CNT_EN
    flush_e = 1;
    for (int i = 0; i < 20; i++) step();
    check("bubble_sat", 32'(bubble_cnt), 32'd15);
    flush_e = 0;
    stall_e = 1;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check("arst_bubble", 32'(bubble_cnt), 32'd0);
    check("arst_stall", 32'(stall_cnt), 32'd0);
    check("arst_taken", 32'(taken_cnt), 32'd0);
    check("arst_validE", 32'(validE), 32'd0);
    m = '{default: '0};
    m.pc_ok = 1;
    bub_m = 0; stl_m = 0; tkn_m = 0;
    @(negedge clk);
    rst = 1'b1;
    stall_e = 0;
    load_d(1, 32'h800, 5'd3, 1, 0, 0, 1, 3'd0);
    step();
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
